func_arbiter: RTL and testbench

FUNC_ARBITER -- requirements
Module: func_arbiter

---
 rtl/func_arb_pkg.sv | 10 +
 rtl/func_arbiter_func.sv | 13 +
 rtl/func_arbiter.sv | 88 ++++++++
 tb/tb_func_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/func_arb_pkg.sv
// func_arb_pkg: shared FSM state encodings and requester id constants for func_arbiter
package func_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;
  localparam logic ID_LOGIC  = 1'b0;
  localparam logic ID_PARITY = 1'b1;
endpackage

// File: rtl/func_arbiter_func.sv
// func_arbiter_func: Func datapath, logic function on D or odd-parity complement on A/B/C
module func_arbiter_func (
  input  logic       sel,
  input  logic [2:0] d,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       out,
  output logic       out_bar
);
  assign out     = sel ? ~(a ^ b ^ c) : (d[0] & d[1]) | d[2];
  assign out_bar = ~out;
endmodule

// File: rtl/func_arbiter.sv
// func_arbiter: round-robin arbiter feeding two requesters through one shared Func datapath
module func_arbiter
  import func_arb_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_d,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_abc,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_out,
  output logic       rsp_out_bar,
  input  logic       rsp_ready,
  output logic       busy
);
  state_t     state;
  logic       ptr;
  logic [2:0] opnd;
  logic       grant;
  logic       take;
  logic [2:0] dp_d;
  logic [2:0] dp_abc;
  logic       dp_out;
  logic       dp_out_bar;
  // pick the sole valid requester, or the pointer on a tie
  always_comb begin
    grant = (req0_valid & req1_valid) ? ptr : (req1_valid ? ID_PARITY : ID_LOGIC);
    take  = !rst && state == IDLE && (req0_valid | req1_valid);
    dp_d  = rsp_id == ID_LOGIC  ? opnd : 3'b000;
    dp_abc = rsp_id == ID_PARITY ? opnd : 3'b000;
  end
  assign req0_ready = take && grant == ID_LOGIC;
  assign req1_ready = take && grant == ID_PARITY;
  func_arbiter_func u_func (
    .sel     (rsp_id),
    .d       (dp_d),
    .a       (dp_abc[2]),
    .b       (dp_abc[1]),
    .c       (dp_abc[0]),
    .out     (dp_out),
    .out_bar (dp_out_bar)
  );
  // accept, evaluate, then hold the response until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= FIRST_PRIO;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_out     <= 1'b0;
      rsp_out_bar <= 1'b1;
      busy        <= 1'b0;
      opnd        <= 3'b000;
    end else begin
      case (state)
        IDLE: if (req0_valid | req1_valid) begin
          rsp_id <= grant;
          opnd   <= grant == ID_PARITY ? req1_abc : req0_d;
          busy   <= 1'b1;
          state  <= EVAL;
        end
        EVAL: begin
          rsp_out     <= dp_out;
          rsp_out_bar <= dp_out_bar;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          ptr       <= ~rsp_id;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_func_arbiter.sv
// tb_func_arbiter: transaction-level model compare plus directed literal checks for func_arbiter
module tb_func_arbiter;
  localparam logic FP = 1'b0;
  logic clk = 0;
  logic rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [2:0] req0_d = 0, req1_abc = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out, rsp_out_bar, busy;
  int cyc = 0;
  int n_run = 0, n_fail = 0;
  bit m_idle = 1, m_valid = 0, m_id = 0, m_out = 0, m_ptr = FP;
  int m_age = 0;

  func_arbiter #(.FIRST_PRIO(FP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_d(req0_d), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_abc(req1_abc), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_out_bar(rsp_out_bar),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit expect_out(input bit id, input logic [2:0] op);
    if (!id) return (op % 4 == 3) || (op >= 4);
    return ($countones(op) % 2) == 0;
  endfunction

  // transaction model: accept in idle, response two edges later, release on handshake
  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1; m_valid = 0; m_id = 0; m_out = 0; m_ptr = FP; m_age = 0;
    end else if (m_idle) begin
      if (req0_valid || req1_valid) begin
        m_id = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        m_out = expect_out(m_id, m_id ? req1_abc : req0_d);
        m_idle = 0;
        m_age = 0;
      end
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid = 0; m_idle = 1; m_ptr = !m_id;
      end
    end else begin
      m_age++;
      if (m_age >= 1) m_valid = 1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (cyc > 0) begin
      chk("m req0_ready", req0_ready, !rst && m_idle && req0_valid && (!req1_valid || m_ptr == 0));
      chk("m req1_ready", req1_ready, !rst && m_idle && req1_valid && (!req0_valid || m_ptr == 1));
      chk("m rsp_valid", rsp_valid, m_valid);
      chk("m busy", busy, !m_idle);
      if (m_valid) begin
        chk("m rsp_id", rsp_id, m_id);
        chk("m rsp_out", rsp_out, m_out);
        chk("m rsp_out_bar", rsp_out_bar, !m_out);
      end
    end
  end

  task automatic serve(input bit v0, input logic [2:0] d, input bit v1, input logic [2:0] abc,
                       input bit eid, input bit eout, input string nm);
    int n;
    bit got;
    @(negedge clk);
    req0_valid = v0; req0_d = d; req1_valid = v1; req1_abc = abc; rsp_ready = 1;
    #3;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (eid ? req1_ready : req0_ready) begin got = 1; break; end
      @(negedge clk); #3;
    end
    n = cyc;
    chk({nm, " grant"}, got, 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #3;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) begin got = 1; break; end
      @(negedge clk); #3;
    end
    chk({nm, " rsp seen"}, got, 1);
    chk({nm, " latency"}, cyc - n, 2);
    chk({nm, " id"}, rsp_id, eid);
    chk({nm, " out"}, rsp_out, eout);
    chk({nm, " out_bar"}, rsp_out_bar, !eout);
  endtask

  task automatic pulse_rst;
    @(negedge clk);
    rst = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int ids[$];
    int cycs[$];
    bit got;
    rst = 1; req0_valid = 1; req1_valid = 1; req0_d = 3'b111; req1_abc = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #3;
      chk("rst req0_ready", req0_ready, 0);
      chk("rst req1_ready", req1_ready, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_out", rsp_out, 0);
      chk("rst rsp_out_bar", rsp_out_bar, 1);
      chk("rst busy", busy, 0);
    end
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
    serve(1, 3'b011, 0, 3'b000, 0, 1, "r0 011");
    serve(1, 3'b001, 0, 3'b000, 0, 0, "r0 001");
    serve(0, 3'b000, 1, 3'b111, 1, 0, "r1 111");
    serve(0, 3'b000, 1, 3'b110, 1, 1, "r1 110");
    pulse_rst();
    req0_valid = 1; req0_d = 3'b111; req1_valid = 1; req1_abc = 3'b000; rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin
      #3;
      if (rsp_valid) begin ids.push_back(rsp_id); cycs.push_back(cyc); end
      @(negedge clk);
    end
    chk("alt count", ids.size() >= 4, 1);
    if (ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("alt order", ids[i], i % 2);
      for (int i = 1; i < 4; i++) chk("alt spacing", cycs[i] - cycs[i-1], 3);
    end
    pulse_rst();
    req0_valid = 1; req0_d = 3'b100; rsp_ready = 0;
    #3;
    chk("bp grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_abc = 3'b011;
    #3;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) begin got = 1; break; end
      @(negedge clk); #3;
    end
    chk("bp rsp seen", got, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", rsp_valid, 1);
      chk("bp hold id", rsp_id, 0);
      chk("bp hold out", rsp_out, 1);
      chk("bp hold out_bar", rsp_out_bar, 0);
      chk("bp no ready", req0_ready | req1_ready, 0);
      @(negedge clk); #3;
    end
    @(negedge clk);
    rsp_ready = 1; req0_valid = 1; req0_d = 3'b000;
    #3;
    chk("bp release valid", rsp_valid, 1);
    @(negedge clk); #3;
    chk("bp idle busy", busy, 0);
    chk("bp idle rsp_valid", rsp_valid, 0);
    chk("bp ptr tie req1", req1_ready, 1);
    chk("bp ptr tie req0", req0_ready, 0);
    pulse_rst();
    req1_valid = 1; req1_abc = 3'b111;
    #3;
    chk("evrst grant", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    #3;
    chk("evrst in eval", busy, 1);
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("evrst no rsp", rsp_valid, 0);
      @(negedge clk);
    end
    req0_valid = 1; req0_d = 3'b000; req1_valid = 1; req1_abc = 3'b000;
    #3;
    chk("evrst tie req0", req0_ready, 1);
    chk("evrst tie req1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
